// File: rtl/conv3x3_stream.sv
// conv3x3_stream
//   Streaming 3x3 convolution engine between the camera pixel stream and the
//   framebuffer write port. Two line buffers hold the previous two lines, so
//   the 3x3 window is formed without any framebuffer reads. One of four kernels
//   is latched on each start-of-frame. Only the interior (IMG_W-2)x(IMG_H-2)
//   pixels are emitted, with start/end-of-frame markers.
//
//   Pipeline (out_valid lands 3 cycles after the qualifying input cycle):
//     1. window capture   2. multiply   3. adder tree + shift + clamp/wrap
//
//   Build option:
//     CONV_SATURATE_EN  defined   -> shifted sum clamped to [0, 2^DW-1]
//                       undefined -> low DW bits of the shifted sum (wrap)
//
//   Ports
//     CLK100MHZ   in   sole clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     in_valid    in   qualifies in_data / in_sof
//     in_data     in   DW-bit unsigned pixel, raster order
//     in_sof      in   first pixel of a frame
//     kernel_sel  in   0 identity, 1 gaussian, 2 sharpen, 3 laplacian edge
//     out_valid   out  qualifies out_data
//     out_data    out  filtered pixel
//     out_sof     out  first output pixel of the frame
//     out_eof     out  last output pixel of the frame
//     busy        out  high while a frame is being received
//     frame_err   out  sticky: start-of-frame seen in the middle of a frame
module conv3x3_stream #(
  parameter int DW    = 8,
  parameter int KW    = 4,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic          CLK100MHZ,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_sof,
  input  logic [1:0]    kernel_sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eof,
  output logic          busy,
  output logic          frame_err
);

  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  // The laplacian centre tap (+8) does not fit a KW=4 signed field, so the
  // coefficients carry one extra bit. Every product still fits DW+KW+1 bits.
  localparam int CFW = KW + 1;
  localparam int PW  = DW + KW + 1;
  localparam int SW  = DW + KW + 5;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  // Coefficient of tap (row-major 0..8) for kernel k.
  function automatic logic signed [CFW-1:0] coef_f(input logic [1:0] k, input int tap);
    logic centre;
    logic corner;
    centre = (tap == 4);
    corner = (tap == 0) || (tap == 2) || (tap == 6) || (tap == 8);
    case (k)
      2'd0:    coef_f = centre ? CFW'(1) : '0;
      2'd1:    coef_f = centre ? CFW'(4) : (corner ? CFW'(1) : CFW'(2));
      2'd2:    coef_f = centre ? CFW'(5) : (corner ? '0 : '1);
      default: coef_f = centre ? CFW'(8) : '1;
    endcase
  endfunction

  // ------------------------------------------------------------------
  // Frame position tracking
  // ------------------------------------------------------------------
  state_t        state_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [1:0]    ksel_reg;

  logic          sof_in;
  logic          accept;
  logic [CW-1:0] pos_col;
  logic [RW-1:0] pos_row;
  logic [1:0]    frame_ksel;
  logic          last_col;
  logic          last_row;
  logic          win_out;

  // A start-of-frame pixel is itself pixel (0,0) of the new frame, whatever
  // state we are in, so the position/kernel seen by this pixel is overridden.
  assign sof_in     = in_valid & in_sof;
  assign accept     = in_valid & (in_sof | (state_reg == ACTIVE));
  assign pos_col    = sof_in ? '0 : col_reg;
  assign pos_row    = sof_in ? '0 : row_reg;
  assign frame_ksel = sof_in ? kernel_sel : ksel_reg;
  assign last_col   = (pos_col == CW'(IMG_W - 1));
  assign last_row   = (pos_row == RW'(IMG_H - 1));
  assign win_out    = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      ksel_reg  <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (sof_in && (state_reg == ACTIVE))
        frame_err <= 1'b1;
      if (sof_in)
        ksel_reg <= kernel_sel;
      if (accept) begin
        if (last_col) begin
          col_reg <= '0;
          row_reg <= pos_row + 1'b1;
        end else begin
          col_reg <= pos_col + 1'b1;
          row_reg <= pos_row;
        end
        if (last_col && last_row) begin
          state_reg <= DONE;
          busy      <= 1'b0;
        end else begin
          state_reg <= ACTIVE;
          busy      <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Line buffers: lb0 holds line r-1, lb1 holds line r-2 at column c.
  // Read-before-write: the old lb0 word shifts down into lb1 as the new
  // pixel replaces it. Contents are never reset; row gating keeps stale
  // data out of the output.
  // ------------------------------------------------------------------
  logic [DW-1:0] lb0_mem [IMG_W];
  logic [DW-1:0] lb1_mem [IMG_W];
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  assign lb0_rd = lb0_mem[pos_col];
  assign lb1_rd = lb1_mem[pos_col];

  always_ff @(posedge CLK100MHZ) begin
    if (accept) begin
      lb0_mem[pos_col] <= in_data;
      lb1_mem[pos_col] <= lb0_rd;
    end
  end

  // ------------------------------------------------------------------
  // Stage 1: window capture. Row 0 of the window is the oldest line.
  // After capturing input (r,c) the window is centred on (r-1,c-1).
  // ------------------------------------------------------------------
  logic [DW-1:0] row_in [3];
  logic [DW-1:0] win_w  [9];
  logic          v1_reg, sof1_reg, eof1_reg;
  logic [1:0]    ksel1_reg;

  assign row_in[0] = lb1_rd;
  assign row_in[1] = lb0_rd;
  assign row_in[2] = in_data;

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_win
    logic [DW-1:0] tap_reg [3];
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
        tap_reg[0] <= '0;
        tap_reg[1] <= '0;
        tap_reg[2] <= '0;
      end else if (accept) begin
        tap_reg[0] <= tap_reg[1];
        tap_reg[1] <= tap_reg[2];
        tap_reg[2] <= row_in[gi];
      end
    end
    assign win_w[3*gi]   = tap_reg[0];
    assign win_w[3*gi+1] = tap_reg[1];
    assign win_w[3*gi+2] = tap_reg[2];
  end

  // The kernel travels with the data so results already in flight keep
  // their own kernel when a new frame restarts mid-stream.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      sof1_reg  <= 1'b0;
      eof1_reg  <= 1'b0;
      ksel1_reg <= '0;
    end else begin
      v1_reg    <= win_out;
      sof1_reg  <= win_out && (pos_row == RW'(2)) && (pos_col == CW'(2));
      eof1_reg  <= win_out && last_row && last_col;
      ksel1_reg <= frame_ksel;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: nine signed products
  // ------------------------------------------------------------------
  logic signed [PW-1:0] prod_w [9];
  logic                 v2_reg, sof2_reg, eof2_reg;
  logic [1:0]           ksel2_reg;

  for (gi = 0; gi < 9; gi++) begin : g_mul
    logic signed [CFW-1:0] coef;
    logic signed [PW-1:0]  pix_s;
    logic signed [PW-1:0]  coef_s;
    logic signed [PW-1:0]  prod_reg;
    assign coef   = coef_f(ksel1_reg, gi);
    assign pix_s  = {{(PW-DW){1'b0}}, win_w[gi]};
    assign coef_s = {{(PW-CFW){coef[CFW-1]}}, coef};
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n)
        prod_reg <= '0;
      else
        prod_reg <= pix_s * coef_s;
    end
    assign prod_w[gi] = prod_reg;
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg    <= 1'b0;
      sof2_reg  <= 1'b0;
      eof2_reg  <= 1'b0;
      ksel2_reg <= '0;
    end else begin
      v2_reg    <= v1_reg;
      sof2_reg  <= sof1_reg;
      eof2_reg  <= eof1_reg;
      ksel2_reg <= ksel1_reg;
    end
  end

  // ------------------------------------------------------------------
  // Stage 3: sum, kernel shift, clamp or wrap, register outputs
  // ------------------------------------------------------------------
  logic signed [SW-1:0] sum_w;
  logic signed [SW-1:0] shifted_w;
  logic [DW-1:0]        res_w;

  always_comb begin
    sum_w = '0;
    for (int i = 0; i < 9; i++)
      sum_w = sum_w + {{(SW-PW){prod_w[i][PW-1]}}, prod_w[i]};
    shifted_w = (ksel2_reg == 2'd1) ? (sum_w >>> 4) : sum_w;
  end

`ifdef CONV_SATURATE_EN
  always_comb begin
    if (shifted_w[SW-1])
      res_w = '0;
    else if (|shifted_w[SW-2:DW])
      res_w = '1;
    else
      res_w = shifted_w[DW-1:0];
  end
`else
  logic unused_hi_bits;
  assign unused_hi_bits = ^shifted_w[SW-1:DW];
  assign res_w          = shifted_w[DW-1:0];
`endif

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= v2_reg;
      out_sof   <= sof2_reg;
      out_eof   <= eof2_reg;
      if (v2_reg)
        out_data <= res_w;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
module tb_conv3x3_stream;

  localparam int DW = 8;
  localparam int KW = 4;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic [1:0]    kernel_sel = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;
  logic          busy;
  logic          frame_err;

  always #5 clk = ~clk;

  conv3x3_stream #(.DW(DW), .KW(KW), .IMG_W(W), .IMG_H(H)) dut (
    .CLK100MHZ (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .kernel_sel(kernel_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   img [H][W];
  int   kcoef [4][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                         '{1, 2, 1, 2, 4, 2, 1, 2, 1},
                         '{0, -1, 0, -1, 5, -1, 0, -1, 0},
                         '{-1, -1, -1, -1, 8, -1, -1, -1, -1}};
  int   kshift [4] = '{0, 4, 0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // Reference: direct 3x3 convolution of the current frame image.
  function automatic logic [7:0] ref_conv(input int k, input int r, input int c);
    int acc = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        acc += kcoef[k][dy*3+dx] * img[r-2+dy][c-2+dx];
    acc = acc >>> kshift[k];
`ifdef CONV_SATURATE_EN
    if (acc < 0) acc = 0;
    else if (acc > 255) acc = 255;
`endif
    return 8'(acc);
  endfunction

  task automatic px(input int r, input int c, input logic sof, input int fk);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = 8'(img[r][c]);
    if (r >= 2 && c >= 2)
      sb.push_back('{ref_conv(fk, r, c), logic'(r == 2 && c == 2),
                     logic'(r == H-1 && c == W-1), cyc + 3});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // Pixels without sof: must be ignored outside a frame.
  task automatic stray(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_sof   = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic frame(input int fk, input int npix, input int gap);
    kernel_sel = 2'(fk);
    for (int i = 0; i < npix; i++) begin
      px(i / W, i % W, i == 0, fk);
      if (gap > 0 && (i % gap) == gap - 1) idle(1);
    end
    idle(1);
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = int'($urandom_range(0, 255));
  endtask

  // Output monitor: every out_valid must match the head of the scoreboard,
  // on the exact cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_sof", out_sof, e.sof);
        chk("out_eof", out_eof, e.eof);
        chk("latency_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("missing_output_due", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_eof", out_eof, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;

    // IDLE ignores pixels without sof
    stray(6);
    idle(5);
    chk("idle_busy", busy, 0);

    // Identity, ramp 0..15: outputs 5,6,9,10 with sof on 5, eof on 10
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = r * W + c;
    kernel_sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      px(i / W, i % W, i == 0, 0);
      if (i == 8) chk("busy_active", busy, 1);
    end
    idle(1);
    chk("busy_after_last", busy, 0);
    idle(5);

    // DONE ignores pixels until sof
    stray(5);
    idle(6);
    chk("done_busy", busy, 0);

    // Gaussian on constant 16 (with input gaps), edge on constant 100
    fill_const(16);
    frame(1, 16, 3);
    idle(4);
    fill_const(100);
    frame(3, 16, 0);
    idle(4);

    // Sharpen: single 255 centre, then 0 centre with four 200 neighbours
    fill_const(0);
    img[1][1] = 255;
    frame(2, 16, 0);
    idle(4);
    fill_const(0);
    img[0][1] = 200; img[1][0] = 200; img[1][2] = 200; img[2][1] = 200;
    frame(2, 16, 2);
    idle(4);

    // kernel_sel change mid-frame has no effect; next frame uses the new one
    fill_rand();
    kernel_sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      px(i / W, i % W, i == 0, 0);
      if (i == 5) kernel_sel = 2'd3;
    end
    idle(1);
    fill_rand();
    frame(3, 16, 0);
    idle(4);
    chk("frame_err_clean", frame_err, 0);

    // sof in the middle of row 2: sticky error, restart at (0,0)
    fill_rand();
    frame(1, 11, 0);
    chk("busy_before_restart", busy, 1);
    fill_rand();
    frame(2, 16, 0);
    chk("frame_err_set", frame_err, 1);
    idle(6);

    // Reset pulse mid-frame while a result is on the output
    fill_rand();
    kernel_sel = 2'd0;
    for (int i = 0; i < 12; i++) px(i / W, i % W, i == 0, 0);
    idle(1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_sof", out_sof, 0);
    chk("midrst_out_eof", out_eof, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_err", frame_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray(6);
    idle(8);
    chk("post_rst_idle_busy", busy, 0);
    fill_rand();
    frame(3, 16, 0);
    idle(8);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
